// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end: NOP word, fetch FSM
// encoding, default reset PC and small address helpers.
package mips_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } fetch_state_t;

  // Instruction fetches are word aligned; the low two target bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Branch wins over jump when ID raises both in the same cycle.
  function automatic logic [31:0] pick_target(input logic        branch_taken,
                                              input logic [31:0] branch_target,
                                              input logic [31:0] jump_target);
    return word_align(branch_taken ? branch_target : jump_target);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / IF-ID / fetch-FSM selection for fetch_stage.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the word fetched alongside a redirect.
module pc_next_sel
  import mips_pkg::*;
(
  input  logic [1:0]  i_state,
  input  logic [31:0] i_pc,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc_next,
  output logic [1:0]  o_state_next,
  output logic        o_ifid_load,
  output logic [31:0] o_ifid_instr,
  output logic [31:0] o_ifid_pc4,
  output logic        o_ifid_valid
);

  fetch_state_t w_state;
  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pc4;

  assign w_state    = fetch_state_t'(i_state);
  assign w_redirect = i_branch_taken | i_jump;
  assign w_target   = pick_target(i_branch_taken, i_branch_target, i_jump_target);
  assign w_pc4      = i_pc + PC_STEP;

  always_comb begin
    o_pc_next    = i_pc;
    o_state_next = i_state;
    o_ifid_load  = 1'b0;
    o_ifid_instr = NOP_WORD;
    o_ifid_pc4   = 32'h0000_0000;
    o_ifid_valid = 1'b0;

    case (w_state)
      ST_BOOT: begin
        o_ifid_load  = 1'b1;
        o_state_next = ST_RUN;
      end
      default: begin
        if (i_stall) begin
          // Hazard hold: PC, IF/ID and state all frozen.
          o_state_next = i_state;
        end else if (w_redirect) begin
          o_pc_next    = w_target;
          o_ifid_load  = 1'b1;
          o_state_next = ST_RUN;
`ifdef BRANCH_DELAY_SLOT_EN
          if (i_imem_ready) begin
            o_ifid_instr = i_imem_rdata;
            o_ifid_pc4   = w_pc4;
            o_ifid_valid = 1'b1;
          end else begin
            o_state_next = ST_WAIT;
          end
`endif
        end else if (!i_imem_ready) begin
          o_ifid_load  = 1'b1;
          o_state_next = ST_WAIT;
        end else begin
          o_pc_next    = w_pc4;
          o_ifid_load  = 1'b1;
          o_ifid_instr = i_imem_rdata;
          o_ifid_pc4   = w_pc4;
          o_ifid_valid = 1'b1;
          o_state_next = ST_RUN;
        end
      end
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, fetch FSM and IF/ID pipeline register.
// Optional macro BRANCH_DELAY_SLOT_EN enables a branch delay slot.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_if_id_instr;
  logic [31:0]  r_if_id_pc4;
  logic         r_if_id_valid;

  logic [31:0]  w_pc_next;
  logic [1:0]   w_state_next;
  logic         w_ifid_load;
  logic [31:0]  w_ifid_instr;
  logic [31:0]  w_ifid_pc4;
  logic         w_ifid_valid;

  pc_next_sel u_pc_next_sel (
    .i_state         (r_state),
    .i_pc            (r_pc),
    .i_stall         (stall),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (jump),
    .i_jump_target   (jump_target),
    .i_imem_ready    (imem_ready),
    .i_imem_rdata    (imem_rdata),
    .o_pc_next       (w_pc_next),
    .o_state_next    (w_state_next),
    .o_ifid_load     (w_ifid_load),
    .o_ifid_instr    (w_ifid_instr),
    .o_ifid_pc4      (w_ifid_pc4),
    .o_ifid_valid    (w_ifid_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= fetch_state_t'(w_state_next);
      r_pc    <= w_pc_next;
    end
  end

  // IF/ID only moves when the selector asks for it, so a stall holds it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_id_instr <= NOP_WORD;
      r_if_id_pc4   <= 32'h0000_0000;
      r_if_id_valid <= 1'b0;
    end else if (w_ifid_load) begin
      r_if_id_instr <= w_ifid_instr;
      r_if_id_pc4   <= w_ifid_pc4;
      r_if_id_valid <= w_ifid_valid;
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_instr = r_if_id_instr;
  assign if_id_pc4   = r_if_id_pc4;
  assign if_id_valid = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural fetch model compared every
// cycle, plus hand-computed pinned expectations at the key directed points.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_boot;
  logic [31:0] m_tgt;

  assign m_tgt = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_boot <= 1'b1;
    end else if (m_boot) begin
      m_boot <= 1'b0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
    end else if (stall) begin
      m_pc <= m_pc;
    end else if (branch_taken || jump) begin
      m_pc <= m_tgt;
`ifdef BRANCH_DELAY_SLOT_EN
      if (imem_ready) begin
        m_instr <= mem_word(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
      end else begin
        m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
      end
`else
      m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
`endif
    end else if (!imem_ready) begin
      m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
    end else begin
      m_instr <= mem_word(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
      m_pc <= m_pc + 32'd4;
    end
  end

  // ---------------- compare process ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        cmp_en  = 1'b0;
  logic        pin_en  = 1'b0;
  logic        pin_full;
  logic [31:0] pin_pc, pin_pc4, pin_instr;
  logic        pin_valid;
  string       pin_name;

  always @(negedge clk) begin
    if (cmp_en) begin
      n_tests++;
      if (imem_addr !== m_pc) begin
        n_fail++;
        $display("FAIL model_imem_addr t=%0t: got %h expected %h", $time, imem_addr, m_pc);
      end
      n_tests++;
      if ({if_id_valid, if_id_pc4, if_id_instr} !== {m_valid, m_pc4, m_instr}) begin
        n_fail++;
        $display("FAIL model_if_id t=%0t: got v=%b pc4=%h instr=%h expected v=%b pc4=%h instr=%h",
                 $time, if_id_valid, if_id_pc4, if_id_instr, m_valid, m_pc4, m_instr);
      end
      if (pin_en) begin
        n_tests++;
        if (imem_addr !== pin_pc) begin
          n_fail++;
          $display("FAIL %s imem_addr: got %h expected %h", pin_name, imem_addr, pin_pc);
        end
        if (pin_full) begin
          n_tests++;
          if ({if_id_valid, if_id_pc4, if_id_instr} !== {pin_valid, pin_pc4, pin_instr}) begin
            n_fail++;
            $display("FAIL %s if_id: got v=%b pc4=%h instr=%h expected v=%b pc4=%h instr=%h",
                     pin_name, if_id_valid, if_id_pc4, if_id_instr, pin_valid, pin_pc4, pin_instr);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input logic [31:0] pc, input logic full,
                     input logic v, input logic [31:0] pc4, input logic [31:0] instr);
    pin_name = name; pin_pc = pc; pin_full = full;
    pin_valid = v; pin_pc4 = pc4; pin_instr = instr;
    pin_en = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jump_target = 32'h0; imem_ready = 1'b1;
    repeat (2) tick();
    cmp_en = 1'b1;
    pin("reset_state", 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    tick(); pin("boot_bubble", 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0);
    tick(); pin("first_fetch", 32'h3004, 1'b1, 1'b1, 32'h3004, 32'h6A5A_C3C3);

    jump = 1'b1; jump_target = 32'h100;
    tick(); jump = 1'b0;
    pin("jump_to_100", 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);

    branch_taken = 1'b1; branch_target = 32'h203;
    tick(); branch_taken = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pin("branch_203", 32'h200, 1'b1, 1'b1, 32'h104, 32'h5B5A_C3C3);
`else
    pin("branch_203", 32'h200, 1'b1, 1'b0, 32'h0, 32'h0);
`endif
    tick(); pin("seq_after_branch", 32'h204, 1'b1, 1'b1, 32'h204, 32'h585A_C3C3);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
    tick(); pin("stall_over_branch", 32'h204, 1'b1, 1'b1, 32'h204, 32'h585A_C3C3);
    stall = 1'b0;
    tick(); branch_taken = 1'b0;
    pin("branch_after_stall", 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);

    jump = 1'b1; jump_target = 32'h40;
    tick(); jump = 1'b0;
    pin("jump_to_40", 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); pin("wait_hold", 32'h40, 1'b1, 1'b0, 32'h0, 32'h0);
    end
    imem_ready = 1'b1;
    tick(); pin("wait_release", 32'h44, 1'b1, 1'b1, 32'h44, 32'h5A1A_C3C3);

    imem_ready = 1'b0;
    tick();
    rst_n = 1'b0; imem_ready = 1'b1;
    pin("async_reset_in_wait", 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0);
    tick(); rst_n = 1'b1;
    tick(); pin("boot_after_reset", 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0);
    tick(); pin("refetch_after_reset", 32'h3004, 1'b1, 1'b1, 32'h3004, 32'h6A5A_C3C3);

    branch_taken = 1'b1; branch_target = 32'h500; rst_n = 1'b0;
    pin("reset_mid_redirect", 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0);
    tick(); pin("redirect_in_reset", 32'h3000, 1'b1, 1'b0, 32'h0, 32'h0);
    branch_taken = 1'b0; rst_n = 1'b1;
    tick(); tick(); pin("fetch_after_redirect_reset", 32'h3004, 1'b0, 1'b0, 32'h0, 32'h0);

    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    tick(); jump = 1'b0;
    pin("align_jump", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
    tick(); pin("pc_wrap", 32'h0, 1'b1, 1'b1, 32'h0, 32'hA5A6_3C3C);

    branch_taken = 1'b1; branch_target = 32'h80; jump = 1'b1; jump_target = 32'hC0;
    tick(); branch_taken = 1'b0; jump = 1'b0;
    pin("branch_over_jump", 32'h80, 1'b0, 1'b0, 32'h0, 32'h0);

    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h600;
    tick(); branch_taken = 1'b0;
    pin("redirect_not_ready", 32'h600, 1'b1, 1'b0, 32'h0, 32'h0);
    imem_ready = 1'b1;
    tick(); pin("resume_after_redirect", 32'h604, 1'b1, 1'b1, 32'h604, 32'h5C5A_C3C3);

    for (int i = 0; i < 40; i++) begin
      stall         = (i % 5 == 3);
      imem_ready    = (i % 4 != 1);
      branch_taken  = (i % 7 == 6);
      branch_target = 32'h1000 + 32'(i) * 32'd16 + 32'd2;
      jump          = (i % 11 == 10);
      jump_target   = 32'h2000 + 32'(i) * 32'd8;
      tick();
    end
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stall  input  1  hazard hold of PC and IF/ID.
REQ-005 SHALL have port branch_taken  input  1  resolved branch decision from ID.
REQ-006 SHALL have port branch_target  input  32  branch destination.
REQ-007 SHALL have port jump  input  1  unconditional jump in ID.
REQ-008 SHALL have port jump_target  input  32  jump destination.
REQ-009 SHALL have port imem_addr  output  32  fetch address, equal to PC.
REQ-010 SHALL have port imem_rdata  input  32  instruction word at imem_addr.
REQ-011 SHALL have port imem_ready  input  1  imem_rdata valid this cycle.
REQ-012 SHALL have ports if_id_instr  output  32, if_id_pc4  output  32, if_id_valid  output  1  IF/ID pipeline register.

Function
REQ-013 SHALL hold an FSM with states BOOT, RUN, WAIT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-014 SHALL, in BOOT, keep PC at RESET_PC and load IF/ID with a bubble (instr 32'h0, pc4 32'h0, valid 0).
REQ-015 SHALL evaluate per cycle, in priority: stall > redirect > !imem_ready > sequential.
REQ-016 SHALL, on stall, hold PC, IF/ID and FSM state; branch_taken/jump ignored that cycle.
REQ-017 SHALL define redirect = branch_taken | jump; branch_target wins if both asserted.
REQ-018 SHALL, on redirect, load PC with target having bits [1:0] forced to 2'b00.
REQ-019 SHALL, on redirect without the delay-slot feature, load an IF/ID bubble and go to RUN.
REQ-020 SHALL, on !imem_ready without stall or redirect, hold PC, load an IF/ID bubble, go to WAIT.
REQ-021 SHALL, in RUN/WAIT with imem_ready, no stall, no redirect: PC <= PC+4, IF/ID <= {imem_rdata, PC+4, 1}, go to RUN.
REQ-022 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 SHALL drive imem_addr combinationally from the PC register, zero latency.
REQ-024 SHALL add one cycle latency from imem_rdata to if_id_instr.

Reset
REQ-025 SHALL, while rst_n low, force PC=RESET_PC, IF/ID bubble, FSM=BOOT, independent of clk.
REQ-026 SHALL, on reset mid-WAIT or mid-redirect, discard pending fetch; no partial IF/ID update.

Configuration
REQ-027 SHALL honour macro BRANCH_DELAY_SLOT_EN.
REQ-028 SHALL, with BRANCH_DELAY_SLOT_EN defined, on redirect with imem_ready load IF/ID with {imem_rdata, PC+4, 1} (slot executes); with !imem_ready load a bubble and go to WAIT at the target.
REQ-029 SHALL, without BRANCH_DELAY_SLOT_EN, always squash the fetched word on redirect (REQ-019).

Structure
REQ-030 SHALL take NOP word, FSM state encoding and default reset PC from shared package mips_pkg.
REQ-031 SHALL place next-PC selection (REQ-015..REQ-022) in combinational sub-module pc_next_sel; state and IF/ID registers stay in fetch_stage.

Verification
REQ-032 SHALL test reset: rst_n low then high, RESET_PC=32'h0000_3000 -> imem_addr 32'h3000, valid 0 one cycle, then 32'h3004 with instr loaded.
REQ-033 SHALL test redirect: PC 32'h100, branch_taken=1, branch_target 32'h203 -> PC 32'h200; valid 0 without macro, valid 1 instr@0x100 with macro.
REQ-034 SHALL test priority: stall=1 with branch_taken=1 -> PC and IF/ID unchanged; next cycle stall=0 -> PC=branch_target.
REQ-035 SHALL test wait: imem_ready=0 for 3 cycles at PC 32'h40 -> PC held, valid 0 each cycle; ready=1 -> IF/ID {rdata, 32'h44, 1}.
REQ-036 SHALL test wrap: PC 32'hFFFF_FFFC, sequential fetch -> PC 32'h0, if_id_pc4 32'h0.
REQ-037 SHALL test branch_taken=1 and jump=1 together, targets 32'h80/32'hC0 -> PC 32'h80.
